spi_master: RTL

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_clk_gen.sv | 62 ++++++
 rtl/spi_master.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master.
//   DATA_W          - bits per transfer
//   CLK_DIV_DEFAULT - default clk cycles per SCK half-period
//   NUM_TOGGLES     - SCK toggles per frame (two per bit)
//   spi_state_e     - controller state encoding
package spi_pkg;

  localparam int DATA_W          = 8;
  localparam int CLK_DIV_DEFAULT = 4;
  localparam int NUM_TOGGLES     = 2 * DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// SCK timing for the SPI master: a half-period down-counter plus a toggle
// counter. Produces single-cycle strobes on the clk edge where SCK moves.
//   clk, rst      - system clock, synchronous active-high reset
//   load          - frame accepted: restart half-period and toggle counts
//   run           - count while the controller is outside IDLE
//   tick          - half-period terminal count (every CLK_DIV cycles)
//   leading       - odd-numbered toggle (1st, 3rd, ... 15th)
//   trailing      - even-numbered toggle (2nd, 4th, ... 16th)
//   last_edge     - the 16th toggle
//   toggles_done  - all 16 toggles have been issued
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic tick,
  output logic leading,
  output logic trailing,
  output logic last_edge,
  output logic toggles_done
);

  localparam logic [7:0] HALF_LAST   = 8'(CLK_DIV - 1);
  localparam logic [4:0] TOGGLE_MAX  = 5'(NUM_TOGGLES);
  localparam logic [4:0] TOGGLE_LAST = 5'(NUM_TOGGLES - 1);

  logic [7:0] half_cnt;
  logic [4:0] edge_cnt;
  logic       toggle;

  assign tick         = run && (half_cnt == 8'd0);
  // Ticks past the 16th toggle still time HOLD and GAP but move no SCK edge.
  assign toggle       = tick && (edge_cnt < TOGGLE_MAX);
  assign leading      = toggle && !edge_cnt[0];
  assign trailing     = toggle && edge_cnt[0];
  assign last_edge    = toggle && (edge_cnt == TOGGLE_LAST);
  assign toggles_done = (edge_cnt == TOGGLE_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      half_cnt <= 8'd0;
      edge_cnt <= 5'd0;
    end else if (load) begin
      half_cnt <= HALF_LAST;
      edge_cnt <= 5'd0;
    end else if (run) begin
      if (half_cnt == 8'd0) begin
        half_cnt <= HALF_LAST;
      end else begin
        half_cnt <= half_cnt - 8'd1;
      end
      if (toggle) begin
        edge_cnt <= edge_cnt + 5'd1;
      end
    end
  end

endmodule

// File: rtl/spi_master.sv
// Single-byte SPI master, all four CPOL/CPHA modes, MSB first.
//   clk, rst   - system clock, synchronous active-high reset
//   start      - one-cycle request; accepted only in IDLE
//   tx_data    - byte to send (latched on acceptance)
//   cpol, cpha - SPI mode (latched on acceptance)
//   rx_data    - last received byte, updated with done
//   busy       - frame in progress (SETUP through GAP)
//   done       - one-cycle pulse when rx_data is loaded
//   sck, ss    - SPI clock and active-low slave select
//   mosi, miso - serial data out / in
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ss high, sck follows live cpol, waiting for start
// SETUP | ss low, bit 7 on mosi, one half-period before first edge
// XFER  | 16 sck toggles, then one trailing half-period at rest
// HOLD  | sck at rest, ss still low for one half-period
// GAP   | ss high, busy high for one half-period before IDLE
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              cpol,
  input  logic              cpha,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sck,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
);

  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] SETUP = ST_SETUP;
  localparam logic [2:0] XFER  = ST_XFER;
  localparam logic [2:0] HOLD  = ST_HOLD;
  localparam logic [2:0] GAP   = ST_GAP;

  logic [2:0]        state;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_shift;
  logic              cpol_q;
  logic              cpha_q;
  logic [2:0]        bit_cnt;
  logic [2:0]        bit_next;

  logic accept;
  logic run;
  logic tick;
  logic leading;
  logic trailing;
  logic last_edge;
  logic toggles_done;
  logic sample_edge;

  assign accept      = (state == IDLE) && start;
  assign run         = (state != IDLE);
  assign bit_next    = bit_cnt - 3'd1;
  assign sample_edge = cpha_q ? trailing : leading;

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk          (clk),
    .rst          (rst),
    .load         (accept),
    .run          (run),
    .tick         (tick),
    .leading      (leading),
    .trailing     (trailing),
    .last_edge    (last_edge),
    .toggles_done (toggles_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_q     <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      bit_cnt  <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sck      <= 1'b0;
      ss       <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      done <= 1'b0;

      case (state)
        IDLE: begin
          ss   <= 1'b1;
          busy <= 1'b0;
          sck  <= cpol;
          if (start) begin
            tx_q     <= tx_data;
            cpol_q   <= cpol;
            cpha_q   <= cpha;
            rx_shift <= '0;
            bit_cnt  <= 3'd7;
            mosi     <= tx_data[DATA_W-1];
            ss       <= 1'b0;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            state <= XFER;
          end
        end
        XFER: begin
          // Leaves one half-period after the 16th toggle, so sck rests
          // at cpol_q for a full half-period before HOLD starts.
          if (tick && toggles_done) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (tick) begin
            ss      <= 1'b1;
            rx_data <= rx_shift;
            done    <= 1'b1;
            state   <= GAP;
          end
        end
        GAP: begin
          if (tick) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Strobes only fire outside IDLE, so these never collide with the
      // IDLE assignments above.
      if (leading || trailing) begin
        sck <= ~sck;
      end

      if (sample_edge) begin
        rx_shift <= {rx_shift[DATA_W-2:0], miso};
      end

      // CPHA=0: bit 7 went out on acceptance; each trailing edge but the
      // last presents the next bit.
      if (!cpha_q && trailing && !last_edge) begin
        bit_cnt <= bit_next;
        mosi    <= tx_q[bit_next];
      end

      // CPHA=1: the leading edge presents the current bit, the trailing
      // edge (where the slave samples) advances to the next.
      if (cpha_q && leading) begin
        mosi <= tx_q[bit_cnt];
      end
      if (cpha_q && trailing) begin
        bit_cnt <= bit_next;
      end
    end
  end

endmodule
